// File: rtl/blur_pkg.sv
// Shared types and constants for the 3x3 blur scheduler.
// Holds the controller state encoding and the tap geometry.
package blur_pkg;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        DRAIN,
        DONE
    } state_t;

    localparam int TAPS = 9;
    localparam int TAP_W = $clog2(TAPS);
    localparam logic [TAP_W-1:0] LAST_TAP = TAP_W'(TAPS - 1);

endpackage

// File: rtl/blur_scheduler_tap_addr_gen.sv
// Clamped 3x3 tap address generator.
// Walks pixels in raster order, nine row-major taps per pixel.
module tap_addr_gen
    import blur_pkg::*;
#(
    parameter int IMG_W  = 64,
    parameter int IMG_H  = 64,
    parameter int ADDR_W = $clog2(IMG_W * IMG_H)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              adv,
    output logic [ADDR_W-1:0] addr,
    output logic [TAP_W-1:0]  tap,
    output logic              last
);

    localparam int XW = $clog2(IMG_W);
    localparam int YW = $clog2(IMG_H);

    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic [1:0]    dx;
    logic [1:0]    dy;
    logic          x_end;
    logic          y_end;
    logic          tap_end;
    int            tx;
    int            ty;

    assign x_end   = (x == XW'(IMG_W - 1));
    assign y_end   = (y == YW'(IMG_H - 1));
    assign tap_end = (tap == LAST_TAP);
    assign last    = tap_end && x_end && y_end;

    // Edge pixels replicate their nearest in-image neighbour.
    always_comb begin
        tx = int'(x) + int'(dx) - 1;
        ty = int'(y) + int'(dy) - 1;
        if (tx < 0) begin
            tx = 0;
        end else if (tx > IMG_W - 1) begin
            tx = IMG_W - 1;
        end
        if (ty < 0) begin
            ty = 0;
        end else if (ty > IMG_H - 1) begin
            ty = IMG_H - 1;
        end
        addr = ADDR_W'(ty * IMG_W + tx);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x   <= '0;
            y   <= '0;
            tap <= '0;
            dx  <= '0;
            dy  <= '0;
        end else if (clr) begin
            x   <= '0;
            y   <= '0;
            tap <= '0;
            dx  <= '0;
            dy  <= '0;
        end else if (adv) begin
            if (tap_end) begin
                tap <= '0;
                dx  <= '0;
                dy  <= '0;
                x   <= x_end ? '0 : x + 1'b1;
                if (x_end) begin
                    y <= y_end ? '0 : y + 1'b1;
                end
            end else begin
                tap <= tap + 1'b1;
                if (dx == 2'd2) begin
                    dx <= '0;
                    dy <= dy + 1'b1;
                end else begin
                    dx <= dx + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/blur_scheduler.sv
// Frame scheduler for an external 3x3 gaussian: fetches clamped taps,
// assembles windows, and writes filtered pixels back in raster order.
module blur_scheduler
    import blur_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int IMG_W  = 64,
    parameter int IMG_H  = 64,
    parameter int ADDR_W = $clog2(IMG_W * IMG_H)
) (
    input  logic               clk_in,
    input  logic               rst_n_in,
    input  logic               start_in,
    output logic               busy_out,
    output logic               done_out,
    output logic               error_out,
    output logic [ADDR_W-1:0]  src_addr_out,
    input  logic [WIDTH-1:0]   src_data_in,
    output logic [3*WIDTH-1:0] blur_r0_out,
    output logic [3*WIDTH-1:0] blur_r1_out,
    output logic [3*WIDTH-1:0] blur_r2_out,
    output logic               blur_valid_out,
    input  logic [WIDTH-1:0]   blur_data_in,
    input  logic               blur_valid_in,
    output logic [ADDR_W-1:0]  dst_addr_out,
    output logic [WIDTH-1:0]   dst_data_out,
    output logic               dst_we_out
);

    localparam int NPIX = IMG_W * IMG_H;
    localparam int CW   = $clog2(NPIX + 1);

    state_t            state;
    logic [ADDR_W-1:0] gen_addr;
    logic [TAP_W-1:0]  gen_tap;
    logic              gen_last;
    logic              fetching;
    logic              active;
    logic [TAP_W-1:0]  tap0;
    logic [TAP_W-1:0]  tap1;
    logic              vld0;
    logic              vld1;
    logic              cap8;
    logic [WIDTH-1:0]  win [TAPS];
    logic [CW-1:0]     wr_cnt;

    assign fetching = (state == FETCH);
    assign active   = (state == FETCH) || (state == DRAIN);

    tap_addr_gen #(
        .IMG_W (IMG_W),
        .IMG_H (IMG_H),
        .ADDR_W(ADDR_W)
    ) u_gen (
        .clk  (clk_in),
        .rst_n(rst_n_in),
        .clr  (state == IDLE),
        .adv  (fetching),
        .addr (gen_addr),
        .tap  (gen_tap),
        .last (gen_last)
    );

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state     <= IDLE;
            busy_out  <= 1'b0;
            done_out  <= 1'b0;
            error_out <= 1'b0;
        end else begin
            done_out  <= 1'b0;
            error_out <= start_in && busy_out;
            unique case (state)
                IDLE: begin
                    if (start_in) begin
                        state    <= FETCH;
                        busy_out <= 1'b1;
                    end
                end
                FETCH: begin
                    if (gen_last) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (wr_cnt == CW'(NPIX)) begin
                        state    <= DONE;
                        busy_out <= 1'b0;
                        done_out <= 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Tap index rides alongside the read so data lands in its window slot.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            src_addr_out   <= '0;
            tap0           <= '0;
            tap1           <= '0;
            vld0           <= 1'b0;
            vld1           <= 1'b0;
            cap8           <= 1'b0;
            blur_valid_out <= 1'b0;
            blur_r0_out    <= '0;
            blur_r1_out    <= '0;
            blur_r2_out    <= '0;
            for (int i = 0; i < TAPS; i++) begin
                win[i] <= '0;
            end
        end else begin
            vld0           <= fetching;
            tap0           <= gen_tap;
            vld1           <= vld0;
            tap1           <= tap0;
            cap8           <= vld1 && (tap1 == LAST_TAP);
            blur_valid_out <= cap8;
            if (fetching) begin
                src_addr_out <= gen_addr;
            end
            if (vld1) begin
                win[tap1] <= src_data_in;
            end
            if (cap8) begin
                blur_r0_out <= {win[0], win[1], win[2]};
                blur_r1_out <= {win[3], win[4], win[5]};
                blur_r2_out <= {win[6], win[7], win[8]};
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            wr_cnt       <= '0;
            dst_we_out   <= 1'b0;
            dst_addr_out <= '0;
            dst_data_out <= '0;
        end else begin
            dst_we_out <= 1'b0;
            if (state == IDLE) begin
                wr_cnt <= '0;
            end else if (active && blur_valid_in) begin
                dst_we_out   <= 1'b1;
                dst_data_out <= blur_data_in;
                dst_addr_out <= wr_cnt[ADDR_W-1:0];
                wr_cnt       <= wr_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_blur_scheduler.sv
// Directed bench for blur_scheduler on a 4x4 image with a
// source BRAM model, a gaussian model and a write scoreboard.
module tb_blur_scheduler;

    localparam int W  = 4;
    localparam int H  = 4;
    localparam int N  = W * H;
    localparam int AW = 4;

    typedef struct packed {
        logic [AW-1:0] a;
        logic [7:0]    d;
    } wr_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic          busy;
    logic          done;
    logic          error;
    logic [AW-1:0] src_addr;
    logic [7:0]    src_data = '0;
    logic [23:0]   r0;
    logic [23:0]   r1;
    logic [23:0]   r2;
    logic          bvalid;
    logic [7:0]    g_data = '0;
    logic          g_valid = 1'b0;
    logic [AW-1:0] dst_addr;
    logic [7:0]    dst_data;
    logic          we;

    logic [7:0] mem [N];
    logic [7:0] dst_img [N];
    wr_t        exp_q [$];
    wr_t        e;
    int         vectors = 0;
    int         miscompares = 0;
    int         done_cnt = 0;

    always #5 clk = ~clk;

    blur_scheduler #(
        .WIDTH (8),
        .IMG_W (W),
        .IMG_H (H),
        .ADDR_W(AW)
    ) dut (
        .clk_in        (clk),
        .rst_n_in      (rst_n),
        .start_in      (start),
        .busy_out      (busy),
        .done_out      (done),
        .error_out     (error),
        .src_addr_out  (src_addr),
        .src_data_in   (src_data),
        .blur_r0_out   (r0),
        .blur_r1_out   (r1),
        .blur_r2_out   (r2),
        .blur_valid_out(bvalid),
        .blur_data_in  (g_data),
        .blur_valid_in (g_valid),
        .dst_addr_out  (dst_addr),
        .dst_data_out  (dst_data),
        .dst_we_out    (we)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] gauss(input logic [23:0] a,
                                         input logic [23:0] b,
                                         input logic [23:0] c);
        int s;
        s = a[23:16] + 2 * a[15:8] + a[7:0]
          + 2 * b[23:16] + 4 * b[15:8] + 2 * b[7:0]
          + c[23:16] + 2 * c[15:8] + c[7:0];
        return 8'(s >> 4);
    endfunction

    function automatic int clampi(input int v, input int hi);
        if (v < 0) return 0;
        if (v > hi) return hi;
        return v;
    endfunction

    function automatic logic [7:0] ref_px(input int x, input int y);
        int s = 0;
        for (int dy = -1; dy <= 1; dy++) begin
            for (int dx = -1; dx <= 1; dx++) begin
                int cx = clampi(x + dx, W - 1);
                int cy = clampi(y + dy, H - 1);
                int wt = (dx == 0 ? 2 : 1) * (dy == 0 ? 2 : 1);
                s += wt * int'(mem[cy * W + cx]);
            end
        end
        return 8'(s / 16);
    endfunction

    // Source BRAM: data for an address issued at edge k is sampled at k+2.
    always @(posedge clk) src_data <= mem[src_addr];

    // External gaussian stand-in, one cycle of latency.
    always @(posedge clk) begin
        g_valid <= bvalid;
        g_data  <= bvalid ? gauss(r0, r1, r2) : 8'd0;
    end

    always @(negedge clk) begin
        if (done) done_cnt++;
        if (we) begin
            check("write_expected", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("write_addr", dst_addr, e.a);
                check("write_data", dst_data, e.d);
            end
            dst_img[dst_addr] = dst_data;
        end
    end

    task automatic push_frame();
        exp_q.delete();
        for (int y = 0; y < H; y++) begin
            for (int x = 0; x < W; x++) begin
                exp_q.push_back(wr_t'{a: AW'(y * W + x), d: ref_px(x, y)});
            end
        end
        for (int i = 0; i < N; i++) dst_img[i] = 8'hff;
        done_cnt = 0;
    endtask

    task automatic fill(input logic [7:0] v);
        for (int i = 0; i < N; i++) mem[i] = v;
    endtask

    task automatic kick();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic finish_frame(input string tag, input bit poke);
        int n = 0;
        while (n < 400 && !done) begin
            @(posedge clk);
            #1 n++;
        end
        check({tag, "_done_seen"}, done, 1);
        if (poke) start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        if (poke) check({tag, "_start_in_done_err"}, error, 0);
        check({tag, "_queue_drained"}, exp_q.size(), 0);
        check({tag, "_done_pulses"}, done_cnt, 1);
        check({tag, "_idle"}, busy, 0);
    endtask

    initial begin
        int first;
        int second;
        rst_n = 1'b0;
        start = 1'b0;
        fill(8'd0);
        repeat (2) @(negedge clk);
        check("rst_ctrl", {busy, done, error, bvalid, we}, 0);
        check("rst_addr", {src_addr, dst_addr, dst_data}, 0);
        check("rst_win", r0 | r1 | r2, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Flat image, latency and strobe spacing.
        fill(8'd100);
        push_frame();
        kick();
        check("busy_after_start", busy, 1);
        first  = -1;
        second = -1;
        for (int i = 1; i <= 25; i++) begin
            @(posedge clk);
            #1;
            if (i == 1) check("src_addr_e1", src_addr, 0);
            if (i == 3) check("src_addr_e3", src_addr, 1);
            if (i == 7) check("src_addr_e7", src_addr, 4);
            if (bvalid) begin
                if (first < 0) first = i;
                else if (second < 0) second = i;
            end
        end
        check("first_strobe_edge", first, 12);
        check("second_strobe_edge", second, 21);
        finish_frame("flat", 1'b1);
        repeat (3) @(posedge clk);
        #1 check("start_in_done_ignored", busy, 0);

        // Single bright centre pixel.
        fill(8'd0);
        mem[5] = 8'd160;
        push_frame();
        kick();
        finish_frame("spot", 1'b0);
        check("spot_dst_1_1", dst_img[5], 40);
        check("spot_dst_0_1", dst_img[4], 20);
        check("spot_dst_0_0", dst_img[0], 10);
        check("spot_dst_3_3", dst_img[15], 0);

        // Corner pixel exercises clamped weights.
        fill(8'd0);
        mem[0] = 8'd16;
        push_frame();
        kick();
        finish_frame("corner", 1'b0);
        check("corner_dst_0_0", dst_img[0], 9);

        // Restart while busy.
        fill(8'd100);
        push_frame();
        kick();
        repeat (30) @(posedge clk);
        kick();
        check("busy_error_pulse", error, 1);
        check("busy_kept", busy, 1);
        @(posedge clk);
        #1 check("busy_error_clear", error, 0);
        finish_frame("restart", 1'b0);

        // Reset mid-fetch, then a clean frame.
        for (int i = 0; i < N; i++) mem[i] = 8'($urandom_range(0, 255));
        push_frame();
        kick();
        repeat (40) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_ctrl", {busy, done, error, bvalid, we}, 0);
        check("midrst_addr", {src_addr, dst_addr, dst_data}, 0);
        check("midrst_win", r0 | r1 | r2, 0);
        exp_q.delete();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(posedge clk);
        #1 check("post_rst_idle", busy, 0);
        push_frame();
        kick();
        finish_frame("after_rst", 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/blur_scheduler.md
BLUR_SCHEDULER -- requirements
Module: blur_scheduler

Interface
REQ-001 Parameter WIDTH, default 8, pixel bit width.
REQ-002 Parameter IMG_W, default 64, image width in pixels (>=2).
REQ-003 Parameter IMG_H, default 64, image height in pixels (>=2).
REQ-004 Parameter ADDR_W, default $clog2(IMG_W*IMG_H), BRAM address width.
REQ-005 Port clk_in, input, 1, sole clock; all logic rising-edge.
REQ-006 Port rst_n_in, input, 1, asynchronous active-low reset.
REQ-007 Port start_in, input, 1, one-cycle request to blur the whole source image.
REQ-008 Port busy_out, output, 1, high from start acceptance until done_out.
REQ-009 Port done_out, output, 1, one-cycle pulse after the last destination write.
REQ-010 Port error_out, output, 1, one-cycle pulse when start_in arrives while busy.
REQ-011 Port src_addr_out, output, ADDR_W, source BRAM read address (read latency fixed at 2 cycles).
REQ-012 Port src_data_in, input, WIDTH, source BRAM read data.
REQ-013 Ports blur_r0_out/blur_r1_out/blur_r2_out, output, 3*WIDTH each, window rows y-1/y/y+1 to gaussian; left pixel in MSBs.
REQ-014 Port blur_valid_out, output, 1, one-cycle window-valid strobe to gaussian.
REQ-015 Ports blur_data_in (WIDTH) and blur_valid_in (1), input, gaussian result and its strobe.
REQ-016 Ports dst_addr_out (ADDR_W), dst_data_out (WIDTH), dst_we_out (1), output, destination BRAM write port.

Function
REQ-017 FSM states IDLE, FETCH, DRAIN, DONE; IDLE->FETCH on start_in; FETCH->DRAIN after the last tap address is issued; DRAIN->DONE when write count equals IMG_W*IMG_H; DONE->IDLE unconditionally after one cycle.
REQ-018 In FETCH, one tap address per cycle, no bubbles: pixels in raster order (y outer, x inner); per pixel 9 taps row-major from (x-1,y-1) to (x+1,y+1).
REQ-019 Tap coordinates clamp to [0,IMG_W-1] x [0,IMG_H-1]; address = y*IMG_W + x.
REQ-020 Tap index travels with each address through a 2-stage delay; returning data is written into the window register slot for that index.
REQ-021 blur_valid_out pulses the cycle after tap 8 data is captured; the r0..r2 outputs hold stable until the next strobe.
REQ-022 Latency: start_in sampled at edge 0 -> first tap address at edge 1 -> first blur_valid_out at edge 12; subsequent strobes every 9 cycles.
REQ-023 Each blur_valid_in produces dst_we_out=1 with dst_data_out=blur_data_in and dst_addr_out=write counter in the same registered cycle (1 cycle after blur_valid_in); counter starts at 0 and increments per write.
REQ-024 blur_valid_in while in IDLE or DONE is ignored (no write).
REQ-025 start_in while busy_out=1: ignored, error_out pulses exactly one cycle; the operation in progress is unaffected.
REQ-026 start_in in DONE is ignored without error; accepted only in IDLE.
REQ-027 Counters sized to hold IMG_W*IMG_H exactly; no wrap within one frame.

Reset
REQ-028 rst_n_in low asynchronously forces IDLE; all counters and window registers to 0; busy_out, done_out, error_out, blur_valid_out, dst_we_out to 0; addresses and data outputs to 0.
REQ-029 Reset mid-frame abandons the frame; in-flight reads and gaussian results arriving after release are ignored until the next start_in.

Structure
REQ-030 Shared package blur_pkg holds the FSM state enum and the tap-count constant (9).
REQ-031 One sub-module, tap_addr_gen: clamped coordinate/address generator with pixel and tap counters, last-tap flag.
REQ-032 The gaussian instance is external; blur_scheduler only connects to it.

Verification
REQ-033 4x4 image, all pixels 100 -> 16 writes, all data 100, addresses 0..15 in order, then done_out once.
REQ-034 4x4 image, pixel (1,1)=160, others 0 -> dst(1,1)=40, dst(0,1)=20, dst(0,0)=10, dst(3,3)=0.
REQ-035 4x4 image, pixel (0,0)=16, others 0 -> dst(0,0)=9 (clamped weights 1+2+2+4).
REQ-036 start_in at edge 0 -> first src_addr_out=0 at edge 1, first blur_valid_out at edge 12, second at edge 21.
REQ-037 start_in re-asserted mid-frame -> error_out high one cycle; output image still identical to REQ-033.
REQ-038 rst_n_in low mid-FETCH -> all outputs 0 immediately; no dst_we_out until a new start_in; full frame afterward correct.
